// File: rtl/mem_arb_if.sv
// Purpose : bundles the fetch (ifu), load/store (lsu) and memory-bus signals of mem_arb.
// Latency : none, wiring only.
// Backpressure: carried by mem_reqReady; the core ports hold reqValid until respValid.
// Ports   : ifu_* fetch request/response, lsu_* load/store request/response,
//           mem_* single downstream bus, bus_err watchdog error flag.
//           modport slave  = arbiter view; modport master = core + memory environment view.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_reqValid;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_respValid;
    logic [DATA_W-1:0]     ifu_rdata;

    logic                  lsu_reqValid;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [1:0]            lsu_size;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_respValid;
    logic [DATA_W-1:0]     lsu_rdata;

    logic                  mem_reqValid;
    logic                  mem_reqReady;
    logic [ADDR_W-1:0]     mem_addr;
    logic [1:0]            mem_size;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_respValid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  bus_err;

    modport slave (
        input  ifu_reqValid, ifu_addr,
        output ifu_respValid, ifu_rdata,
        input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata,
        output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        input  mem_reqReady, mem_respValid, mem_rdata,
        output bus_err
    );

    modport master (
        output ifu_reqValid, ifu_addr,
        input  ifu_respValid, ifu_rdata,
        output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata,
        input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        output mem_reqReady, mem_respValid, mem_rdata,
        input  bus_err
    );
endinterface

// File: rtl/mem_arb.sv
// Purpose : two-master (ifu, lsu) to one-slave memory arbiter, LSU has fixed priority,
//           one transaction outstanding, request fields latched at grant.
// Latency : grant N -> mem_reqValid N+1 -> respValid to master N+3 at minimum.
// Backpressure: holds mem_reqValid with stable fields until mem_reqReady; waits in WAIT for
//           mem_respValid. Optional watchdog under macro MEM_ARB_TIMEOUT_EN answers with
//           0xDEAD_BEEF and bus_err after TIMEOUT WAIT cycles; otherwise bus_err is tied 0.
// Ports   : clock, reset (async, active-low), bus (mem_arb_if.slave).
module mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic      clock,
    input  logic      reset,
    mem_arb_if.slave  bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    // Counter is at least 8 bits so small TIMEOUT values still fit comfortably.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IFU;
            addr_q      <= '0;
            size_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                // Requests are only looked at here; LSU wins a tie.
                if (bus.lsu_reqValid) begin
                    owner_d = OWN_LSU;
                    addr_d  = bus.lsu_addr;
                    size_d  = bus.lsu_size;
                    wen_d   = bus.lsu_wen;
                    wdata_d = bus.lsu_wdata;
                    wmask_d = bus.lsu_wmask;
                    state_d = REQ;
                end else if (bus.ifu_reqValid) begin
                    // Fetches are always a full-word read.
                    owner_d = OWN_IFU;
                    addr_d  = bus.ifu_addr;
                    size_d  = 2'b10;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_reqReady) begin
                    state_d = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                // A real response in the watchdog cycle wins over the timeout.
                if (bus.mem_respValid) begin
                    if (owner_q == OWN_LSU) lsu_rdata_d = bus.mem_rdata;
                    else                    ifu_rdata_d = bus.mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    if (owner_q == OWN_LSU) lsu_rdata_d = DATA_W'(ERR_WORD);
                    else                    ifu_rdata_d = DATA_W'(ERR_WORD);
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_reqValid  = (state_q == REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_size      = size_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
    assign bus.ifu_respValid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign bus.lsu_respValid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign bus.ifu_rdata     = ifu_rdata_q;
    assign bus.lsu_rdata     = lsu_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.bus_err       = (state_q == RESP) && err_q;
`else
    assign bus.bus_err       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arb.sv
// Purpose : self-checking bench for mem_arb; transaction-level model compared every cycle,
//           directed scenarios with literal expectations, then randomized ifu/lsu mixes.
// Latency : n/a.
// Backpressure: bench memory randomises mem_reqReady and response delay.
module tb_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TB_TO = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TB_TO = 0;
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arb #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(TB_TO)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // master-side request state
    bit ifu_want, lsu_want, ifu_done, lsu_done;
    logic [31:0] ifu_addr_v, lsu_addr_v, lsu_wdata_v;
    logic [1:0]  lsu_size_v;
    logic        lsu_wen_v;
    logic [3:0]  lsu_wmask_v;

    // stimulus knobs
    bit rand_mode, force_stray;
    int rdy_hold, resp_delay;
    logic [31:0] resp_data;

    // transaction-level model: one outstanding transaction and its progress
    bit m_busy, m_acc, m_ans, m_err, m_own_lsu;
    logic [31:0] m_addr, m_wdata, m_ifu_rd, m_lsu_rd;
    logic [1:0]  m_size;
    logic        m_wen;
    logic [3:0]  m_wmask;
    int m_wait, m_req_cyc, completions, ifu_pulses, lsu_pulses;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_masters();
        bus.ifu_reqValid = ifu_want;
        bus.ifu_addr     = ifu_addr_v;
        bus.lsu_reqValid = lsu_want;
        bus.lsu_addr     = lsu_addr_v;
        bus.lsu_size     = lsu_size_v;
        bus.lsu_wen      = lsu_wen_v;
        bus.lsu_wdata    = lsu_wdata_v;
        bus.lsu_wmask    = lsu_wmask_v;
    endtask

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_ans = 0; m_err = 0; m_own_lsu = 0;
        m_ifu_rd = '0; m_lsu_rd = '0;
        ifu_want = 0; lsu_want = 0; ifu_done = 0; lsu_done = 0;
        drive_masters();
        bus.mem_reqReady = 1'b0; bus.mem_respValid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reqValid"}, bus.mem_reqValid, 0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_size"},  bus.mem_size, 0);
        chk({tag, "_wen"},   bus.mem_wen, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_wmask"}, bus.mem_wmask, 0);
        chk({tag, "_ifu_resp"}, bus.ifu_respValid, 0);
        chk({tag, "_lsu_resp"}, bus.lsu_respValid, 0);
        chk({tag, "_ifu_rdata"}, bus.ifu_rdata, 0);
        chk({tag, "_lsu_rdata"}, bus.lsu_rdata, 0);
        chk({tag, "_bus_err"}, bus.bus_err, 0);
    endtask

    // One clock: compare outputs with the model, drive inputs, advance the model.
    task automatic step();
        bit exp_rv, rdy, rv;
        exp_rv = m_busy && !m_acc;
        chk("mem_reqValid", bus.mem_reqValid, exp_rv);
        if (exp_rv) begin
            chk("mem_addr",  bus.mem_addr,  m_addr);
            chk("mem_size",  bus.mem_size,  m_size);
            chk("mem_wen",   bus.mem_wen,   m_wen);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("mem_wmask", bus.mem_wmask, m_wmask);
        end
        chk("ifu_respValid", bus.ifu_respValid, m_ans && !m_own_lsu);
        chk("lsu_respValid", bus.lsu_respValid, m_ans && m_own_lsu);
        chk("bus_err",       bus.bus_err,       m_ans && m_err);
        chk("ifu_rdata",     bus.ifu_rdata,     m_ifu_rd);
        chk("lsu_rdata",     bus.lsu_rdata,     m_lsu_rd);
        if (bus.ifu_respValid) ifu_pulses++;
        if (bus.lsu_respValid) lsu_pulses++;

        // masters drop their request in the response cycle
        ifu_done = 0; lsu_done = 0;
        if (m_ans) begin
            if (m_own_lsu) begin lsu_want = 0; lsu_done = 1; end
            else           begin ifu_want = 0; ifu_done = 1; end
        end
        if (rand_mode) begin
            if (!ifu_want && !ifu_done && $urandom_range(0, 3) == 0) begin
                ifu_want = 1; ifu_addr_v = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_want && !lsu_done && $urandom_range(0, 3) == 0) begin
                lsu_want = 1; lsu_addr_v = $urandom; lsu_size_v = 2'($urandom_range(0, 3));
                lsu_wen_v = 1'($urandom_range(0, 1)); lsu_wdata_v = $urandom;
                lsu_wmask_v = 4'($urandom_range(0, 15));
            end
        end
        drive_masters();

        // memory side
        if (m_busy && !m_acc) rdy = rand_mode ? ($urandom_range(0, 2) != 0) : (m_req_cyc >= rdy_hold);
        else                  rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        if (m_acc && !m_ans)        rv = (m_wait >= resp_delay);
        else if (!m_busy || !m_acc) rv = force_stray || (rand_mode && $urandom_range(0, 7) == 0);
        else                        rv = 1'b0;
        bus.mem_reqReady  = rdy;
        bus.mem_respValid = rv;
        bus.mem_rdata     = rand_mode ? $urandom : resp_data;

        // model advance
        if (!m_busy) begin
            if (lsu_want || ifu_want) begin
                m_busy = 1; m_acc = 0; m_ans = 0; m_req_cyc = 0;
                m_own_lsu = lsu_want;
                if (lsu_want) begin
                    m_addr = lsu_addr_v; m_size = lsu_size_v; m_wen = lsu_wen_v;
                    m_wdata = lsu_wdata_v; m_wmask = lsu_wmask_v;
                end else begin
                    m_addr = ifu_addr_v; m_size = 2'b10; m_wen = 0; m_wdata = 0; m_wmask = 0;
                end
            end
        end else if (!m_acc) begin
            if (rdy) begin
                m_acc = 1; m_wait = 0;
                if (rand_mode) resp_delay = $urandom_range(0, TO_EN ? 12 : 5);
            end else m_req_cyc++;
        end else if (!m_ans) begin
            if (rv) begin
                m_ans = 1; m_err = 0;
                if (m_own_lsu) m_lsu_rd = bus.mem_rdata; else m_ifu_rd = bus.mem_rdata;
            end else if (TO_EN && m_wait + 1 == TB_TO) begin
                m_ans = 1; m_err = 1;
                if (m_own_lsu) m_lsu_rd = 32'hDEAD_BEEF; else m_ifu_rd = 32'hDEAD_BEEF;
            end else m_wait++;
        end else begin
            m_busy = 0; m_acc = 0; m_ans = 0; completions++;
        end

        @(negedge clock);
        cyc++;
    endtask

    initial begin
        int g, pulse_at, reqv, lp, ip, first, start_c, start_p;
        rand_mode = 0; force_stray = 0; rdy_hold = 0; resp_delay = 0; resp_data = '0;
        ifu_addr_v = '0; lsu_addr_v = '0; lsu_wdata_v = '0; lsu_size_v = '0;
        lsu_wen_v = 0; lsu_wmask_v = '0;
        completions = 0; ifu_pulses = 0; lsu_pulses = 0;
        model_reset();
        repeat (2) @(negedge clock);
        chk_all_zero("rst");
        reset = 1'b1;

        // 1: single fetch, minimum latency
        resp_data = 32'h0000_0013; ifu_want = 1; ifu_addr_v = 32'h8000_0000;
        g = cyc;
        step();
        chk("t1_reqValid", bus.mem_reqValid, 1);
        chk("t1_addr", bus.mem_addr, 32'h8000_0000);
        chk("t1_size", bus.mem_size, 2'b10);
        chk("t1_wen", bus.mem_wen, 0);
        chk("t1_wmask", bus.mem_wmask, 0);
        pulse_at = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.ifu_respValid && pulse_at < 0) begin
                pulse_at = cyc;
                chk("t1_rdata", bus.ifu_rdata, 32'h13);
            end
            step();
        end
        chk("t1_latency", pulse_at - g, 3);

        // 2: store with 4 cycles of backpressure
        lsu_want = 1; lsu_addr_v = 32'h100; lsu_wen_v = 1; lsu_wdata_v = 32'hAB00;
        lsu_wmask_v = 4'b0010; lsu_size_v = 2'b10; rdy_hold = 4; resp_delay = 1;
        resp_data = 32'h1234; reqv = 0; lp = 0; ip = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_reqValid) begin
                reqv++;
                chk("t2_addr", bus.mem_addr, 32'h100);
                chk("t2_wdata", bus.mem_wdata, 32'hAB00);
            end
            if (bus.lsu_respValid) lp++;
            if (bus.ifu_respValid) ip++;
            step();
        end
        chk("t2_req_cycles", reqv, 5);
        chk("t2_lsu_pulses", lp, 1);
        chk("t2_ifu_pulses", ip, 0);

        // 3: simultaneous requests, LSU first
        rdy_hold = 0; resp_data = 32'h5555_AAAA;
        lsu_want = 1; lsu_addr_v = 32'h200; lsu_wen_v = 0;
        ifu_want = 1; ifu_addr_v = 32'h300;
        first = 0; lp = 0; ip = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.lsu_respValid) begin lp++; if (first == 0) first = 2; end
            if (bus.ifu_respValid) begin ip++; if (first == 0) first = 1; end
            step();
        end
        chk("t3_first_is_lsu", first, 2);
        chk("t3_lsu_pulses", lp, 1);
        chk("t3_ifu_pulses", ip, 1);

        // 4: reset while in WAIT, then a stray response
        ifu_want = 1; ifu_addr_v = 32'h400; resp_delay = 1000;
        repeat (3) step();
        chk("t4_in_wait", bus.mem_reqValid, 0);
        reset = 1'b0;
        #1;
        chk_all_zero("t4");
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        force_stray = 1;
        step();
        force_stray = 0;
        lp = lsu_pulses; ip = ifu_pulses;
        repeat (6) step();
        chk("t4_no_pulse", (lsu_pulses - lp) + (ifu_pulses - ip), 0);

        // 5: no response from memory
        lsu_want = 1; lsu_addr_v = 32'h500; lsu_wen_v = 0; resp_delay = 100000;
        g = cyc; pulse_at = -1; lp = lsu_pulses;
        for (int i = 0; i < 300; i++) begin
            if (bus.lsu_respValid && pulse_at < 0) begin
                pulse_at = cyc;
                chk("t5_rdata", bus.lsu_rdata, 32'hDEAD_BEEF);
                chk("t5_bus_err", bus.bus_err, 1);
            end
            step();
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("t5_timeout_at", pulse_at - g, TB_TO + 2);
`else
        chk("t5_no_pulse", pulse_at < 0, 1);
        resp_delay = 0; resp_data = 32'h77;
        repeat (5) step();
`endif
        chk("t5_lsu_pulses", lsu_pulses - lp, 1);

        // 6: randomized ifu/lsu mixes with back-to-back re-requests
        rand_mode = 1;
        start_c = completions; start_p = ifu_pulses + lsu_pulses;
        for (int i = 0; i < 6000 && completions - start_c < 100; i++) step();
        chk("t6_completed", completions - start_c >= 100, 1);
        chk("t6_pulse_count", (ifu_pulses + lsu_pulses) - start_p, completions - start_c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
